// File: rtl/regfile_sb_if.sv
// Register-file bundle: write-back port, decode read ports, issue handshake.
// master drives toward the register file; slave is the register file.
interface regfile_sb_if #(
  parameter int XLEN = 64
);
  logic            i_wbu_rdwen;
  logic [4:0]      i_wbu_rdid;
  logic [XLEN-1:0] i_wbu_rd;
  logic [4:0]      i_idu_rs1id;
  logic [4:0]      i_idu_rs2id;
  logic [XLEN-1:0] o_idu_rs1;
  logic [XLEN-1:0] o_idu_rs2;
  logic            i_iss_valid;
  logic            o_iss_ready;
  logic            i_iss_rs1en;
  logic            i_iss_rs2en;
  logic            i_iss_rdwen;
  logic [4:0]      i_iss_rdid;
  logic            o_busy;
  logic            o_sb_err;

  modport master (
    output i_wbu_rdwen, i_wbu_rdid, i_wbu_rd,
    output i_idu_rs1id, i_idu_rs2id,
    output i_iss_valid, i_iss_rs1en, i_iss_rs2en,
    output i_iss_rdwen, i_iss_rdid,
    input  o_idu_rs1, o_idu_rs2, o_iss_ready,
    input  o_busy, o_sb_err
  );

  modport slave (
    input  i_wbu_rdwen, i_wbu_rdid, i_wbu_rd,
    input  i_idu_rs1id, i_idu_rs2id,
    input  i_iss_valid, i_iss_rs1en, i_iss_rs2en,
    input  i_iss_rdwen, i_iss_rdid,
    output o_idu_rs1, o_idu_rs2, o_iss_ready,
    output o_busy, o_sb_err
  );
endinterface

// File: rtl/regfile_sb.sv
// 32 x XLEN integer register file with write-back bypass and
// a per-register pending-write scoreboard gating issue.
module regfile_sb #(
  parameter int XLEN  = 64,
  parameter int PCNTW = 2
) (
  input logic         i_clk,
  input logic         i_rst_n,
  regfile_sb_if.slave bus
);
  localparam logic [PCNTW-1:0] PMAX = '1;
  localparam logic [PCNTW-1:0] ONE  =
    {{(PCNTW-1){1'b0}}, 1'b1};

  logic [XLEN-1:0]  rf   [32];
  logic [PCNTW-1:0] pend [32];
  logic [31:0]      wb_hit;
  logic [31:0]      inc;
  logic [31:0]      dec;
  logic             haz1;
  logic             haz2;
  logic             hazd;
  logic             ready;
  logic             fire;
  logic             busy;
  logic             sb_err;

  always_comb begin
    wb_hit = '0;
    if (bus.i_wbu_rdwen && bus.i_wbu_rdid != 5'd0)
      wb_hit[bus.i_wbu_rdid] = 1'b1;
  end

  always_comb begin
    bus.o_idu_rs1 = '0;
    if (bus.i_idu_rs1id == 5'd0)
      bus.o_idu_rs1 = '0;
    else if (wb_hit[bus.i_idu_rs1id])
      bus.o_idu_rs1 = bus.i_wbu_rd;
    else
      bus.o_idu_rs1 = rf[bus.i_idu_rs1id];
  end

  always_comb begin
    bus.o_idu_rs2 = '0;
    if (bus.i_idu_rs2id == 5'd0)
      bus.o_idu_rs2 = '0;
    else if (wb_hit[bus.i_idu_rs2id])
      bus.o_idu_rs2 = bus.i_wbu_rd;
    else
      bus.o_idu_rs2 = rf[bus.i_idu_rs2id];
  end

  // last outstanding write being bypassed now does not stall
  always_comb begin
    haz1 = bus.i_iss_rs1en
      && bus.i_idu_rs1id != 5'd0
      && pend[bus.i_idu_rs1id] != '0
      && !(pend[bus.i_idu_rs1id] == ONE
           && wb_hit[bus.i_idu_rs1id]);
    haz2 = bus.i_iss_rs2en
      && bus.i_idu_rs2id != 5'd0
      && pend[bus.i_idu_rs2id] != '0
      && !(pend[bus.i_idu_rs2id] == ONE
           && wb_hit[bus.i_idu_rs2id]);
    hazd = bus.i_iss_rdwen
      && bus.i_iss_rdid != 5'd0
      && pend[bus.i_iss_rdid] == PMAX
      && !wb_hit[bus.i_iss_rdid];
  end

  assign ready = !haz1 && !haz2 && !hazd;
  assign fire  = bus.i_iss_valid && ready;

  always_comb begin
    inc  = '0;
    dec  = '0;
    busy = 1'b0;
    for (int r = 1; r < 32; r++) begin
      inc[r] = fire && bus.i_iss_rdwen
        && bus.i_iss_rdid == 5'(r);
      dec[r] = wb_hit[r] && pend[r] != '0;
      busy   = busy | (pend[r] != '0);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int r = 0; r < 32; r++) begin
        rf[r]   <= '0;
        pend[r] <= '0;
      end
      sb_err <= 1'b0;
    end else begin
      if (wb_hit[bus.i_wbu_rdid])
        rf[bus.i_wbu_rdid] <= bus.i_wbu_rd;
      for (int r = 1; r < 32; r++) begin
        if (inc[r] && !dec[r])
          pend[r] <= pend[r] + ONE;
        else if (dec[r] && !inc[r])
          pend[r] <= pend[r] - ONE;
      end
      if (wb_hit[bus.i_wbu_rdid]
          && pend[bus.i_wbu_rdid] == '0)
        sb_err <= 1'b1;
    end
  end

  assign bus.o_iss_ready = ready;
  assign bus.o_busy      = busy;
  assign bus.o_sb_err    = sb_err;
endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb: bypass, RAW stall,
// counter saturation, underflow error, async reset.
module tb_regfile_sb;
  localparam int XLEN = 64;

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_fail;

  regfile_sb_if #(.XLEN(XLEN)) bus ();

  regfile_sb #(.XLEN(XLEN), .PCNTW(2)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic idle();
    bus.i_wbu_rdwen = 1'b0;
    bus.i_wbu_rdid  = '0;
    bus.i_wbu_rd    = '0;
    bus.i_idu_rs1id = '0;
    bus.i_idu_rs2id = '0;
    bus.i_iss_valid = 1'b0;
    bus.i_iss_rs1en = 1'b0;
    bus.i_iss_rs2en = 1'b0;
    bus.i_iss_rdwen = 1'b0;
    bus.i_iss_rdid  = '0;
  endtask

  task automatic wb(input logic [4:0] id,
                    input logic [63:0] d);
    bus.i_wbu_rdwen = 1'b1;
    bus.i_wbu_rdid  = id;
    bus.i_wbu_rd    = d;
  endtask

  task automatic iss_rd(input logic [4:0] id);
    bus.i_iss_valid = 1'b1;
    bus.i_iss_rdwen = 1'b1;
    bus.i_iss_rdid  = id;
  endtask

  task automatic cyc();
    @(negedge clk);
    idle();
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    rst_n  = 1'b0;
    idle();
    bus.i_idu_rs1id = 5'd5;
    #1;
    check("rst_rs1", bus.o_idu_rs1, 64'h0);
    check("rst_rs2", bus.o_idu_rs2, 64'h0);
    check("rst_busy", 64'(bus.o_busy), 64'h0);
    check("rst_ready", 64'(bus.o_iss_ready), 64'h1);
    check("rst_err", 64'(bus.o_sb_err), 64'h0);
    @(negedge clk);
    rst_n = 1'b1;

    cyc();
    wb(5'd3, 64'hDEAD);
    bus.i_idu_rs1id = 5'd3;
    #1 check("bypass", bus.o_idu_rs1, 64'hDEAD);
    cyc();
    bus.i_idu_rs1id = 5'd3;
    #1 check("rf_read", bus.o_idu_rs1, 64'hDEAD);
    check("uflow_err", 64'(bus.o_sb_err), 64'h1);
    cyc();
    #1 check("err_sticky", 64'(bus.o_sb_err), 64'h1);

    #2 rst_n = 1'b0;
    #1 check("err_rst", 64'(bus.o_sb_err), 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    bus.i_idu_rs1id = 5'd3;
    #1 check("rf_cleared", bus.o_idu_rs1, 64'h0);

    cyc();
    wb(5'd0, 64'h7);
    bus.i_idu_rs1id = 5'd0;
    #1 check("x0_bypass", bus.o_idu_rs1, 64'h0);
    cyc();
    #1 check("x0_no_err", 64'(bus.o_sb_err), 64'h0);

    cyc();
    iss_rd(5'd7);
    #1 check("raw_iss", 64'(bus.o_iss_ready), 64'h1);
    for (int i = 0; i < 2; i++) begin
      cyc();
      bus.i_iss_valid = 1'b1;
      bus.i_iss_rs1en = 1'b1;
      bus.i_idu_rs1id = 5'd7;
      #1 check("raw_stall", 64'(bus.o_iss_ready), 64'h0);
      check("raw_busy", 64'(bus.o_busy), 64'h1);
    end
    cyc();
    bus.i_iss_valid = 1'b1;
    bus.i_iss_rs1en = 1'b1;
    bus.i_idu_rs1id = 5'd7;
    wb(5'd7, 64'h1234);
    #1 check("raw_wb_rdy", 64'(bus.o_iss_ready), 64'h1);
    check("raw_wb_data", bus.o_idu_rs1, 64'h1234);
    cyc();
    bus.i_idu_rs1id = 5'd7;
    #1 check("raw_idle", 64'(bus.o_busy), 64'h0);
    check("raw_rf", bus.o_idu_rs1, 64'h1234);

    cyc();
    iss_rd(5'd8);
    cyc();
    bus.i_iss_rs2en = 1'b1;
    bus.i_idu_rs2id = 5'd8;
    #1 check("rs2_stall", 64'(bus.o_iss_ready), 64'h0);
    cyc();
    wb(5'd8, 64'h88);
    cyc();
    bus.i_iss_rs2en = 1'b1;
    bus.i_idu_rs2id = 5'd8;
    #1 check("rs2_clear", 64'(bus.o_iss_ready), 64'h1);
    check("rs2_data", bus.o_idu_rs2, 64'h88);

    for (int i = 0; i < 3; i++) begin
      cyc();
      iss_rd(5'd9);
      #1 check("sat_fill", 64'(bus.o_iss_ready), 64'h1);
    end
    cyc();
    iss_rd(5'd9);
    #1 check("sat_stall", 64'(bus.o_iss_ready), 64'h0);
    wb(5'd9, 64'h99);
    #1 check("sat_wb_rdy", 64'(bus.o_iss_ready), 64'h1);
    cyc();
    iss_rd(5'd9);
    #1 check("sat_still3", 64'(bus.o_iss_ready), 64'h0);
    for (int i = 0; i < 3; i++) begin
      cyc();
      wb(5'd9, 64'h90 + 64'(i));
    end
    cyc();
    #1 check("sat_drain", 64'(bus.o_busy), 64'h0);
    check("sat_no_err", 64'(bus.o_sb_err), 64'h0);

    cyc();
    bus.i_iss_valid = 1'b1;
    bus.i_iss_rs1en = 1'b1;
    bus.i_idu_rs1id = 5'd10;
    bus.i_iss_rdwen = 1'b1;
    bus.i_iss_rdid  = 5'd10;
    #1 check("self_dep", 64'(bus.o_iss_ready), 64'h1);
    cyc();
    wb(5'd10, 64'hA);
    cyc();
    #1 check("self_drain", 64'(bus.o_busy), 64'h0);

    cyc();
    iss_rd(5'd12);
    cyc();
    iss_rd(5'd12);
    wb(5'd12, 64'h55);
    cyc();
    bus.i_idu_rs1id = 5'd12;
    #1 check("mid_busy", 64'(bus.o_busy), 64'h1);
    check("mid_rf", bus.o_idu_rs1, 64'h55);
    #2 rst_n = 1'b0;
    #1 check("mid_rst_busy", 64'(bus.o_busy), 64'h0);
    check("mid_rst_rdy", 64'(bus.o_iss_ready), 64'h1);
    @(negedge clk);
    rst_n = 1'b1;
    #1 check("mid_rf_zero", bus.o_idu_rs1, 64'h0);
    check("mid_err", 64'(bus.o_sb_err), 64'h0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/regfile_sb.md
# regfile_sb

Integer register file with a write-back scoreboard: the receiving end of the write-back port driven by the WB stage. It stores 32 x XLEN architectural registers, serves two combinational read ports to decode with same-cycle write-back bypass, and tracks pending writes per register. An issue handshake toward decode stalls any instruction whose operands or destination would cause a RAW hazard or overflow a pending-write counter.

## Interface

Parameters:
- XLEN, 64, register data width.
- PCNTW, 2, width of each per-register pending-write counter; maximum `PMAX = 2^PCNTW - 1`.

Ports:
- i_clk  in  1  clock; all state updates on rising edge.
- i_rst_n  in  1  reset; asynchronous, active-low.
- i_wbu_rdwen  in  1  write-back enable; already qualified by the WB stage's valid.
- i_wbu_rdid  in  5  write-back register index.
- i_wbu_rd  in  XLEN  write-back data.
- i_idu_rs1id  in  5  read port 1 index.
- i_idu_rs2id  in  5  read port 2 index.
- o_idu_rs1  out  XLEN  read port 1 data, combinational.
- o_idu_rs2  out  XLEN  read port 2 data, combinational.
- i_iss_valid  in  1  decode presents an instruction for issue.
- o_iss_ready  out  1  scoreboard accepts the issue this cycle.
- i_iss_rs1en  in  1  instruction reads rs1 (index from i_idu_rs1id).
- i_iss_rs2en  in  1  instruction reads rs2 (index from i_idu_rs2id).
- i_iss_rdwen  in  1  instruction writes rd.
- i_iss_rdid  in  5  destination index.
- o_busy  out  1  any pending counter nonzero.
- o_sb_err  out  1  sticky: write-back arrived for a register with pending count 0.

## Operation

- x0 always reads 0. Writes to x0 are discarded. x0 is never pending and never stalls.
- Write: when i_wbu_rdwen and i_wbu_rdid != 0, `rf[i_wbu_rdid] <= i_wbu_rd` at the edge.
- Read, port 1: if i_idu_rs1id == 0, output 0. Else if i_wbu_rdwen and i_wbu_rdid == i_idu_rs1id, output i_wbu_rd (bypass). Else output `rf[i_idu_rs1id]`. Port 2 is identical.
- Definitions:
  - `wbhit(r)` = i_wbu_rdwen & i_wbu_rdid == r & r != 0.
  - `pend[r]` = the pending-write counter of register r.
- Operand hazard for rsN: rsNen & rsNid != 0 & `pend[rsNid] != 0`, except when `pend[rsNid] == 1` & `wbhit(rsNid)`. That exception is the last outstanding write, which is bypassed this cycle.
- Destination hazard: i_iss_rdwen & i_iss_rdid != 0 & `pend[rdid] == PMAX` & !`wbhit(rdid)`.
- o_iss_ready = no rs1 hazard & no rs2 hazard & no destination hazard. It is independent of i_iss_valid, so it must not combinationally depend on it.
- Issue fires on i_iss_valid & o_iss_ready.
- Per-register counter update at the edge, for r != 0:
  - inc = fire & i_iss_rdwen & i_iss_rdid == r.
  - dec = `wbhit(r)` & `pend[r] != 0`.
  - inc & dec: unchanged. inc only: +1. dec only: −1.
- Underflow: `wbhit(r)` with `pend[r] == 0` leaves the counter at 0 and sets o_sb_err. o_sb_err clears only on reset.
- o_busy = OR of all `pend[r] != 0`, taken from registered state.

## Timing

- Reset (asynchronous assert, synchronous-release-safe): all rf entries 0, all pend 0, o_sb_err 0.
- Outputs during reset: o_busy 0, o_iss_ready 1. Read outputs are 0 unless bypassed.
- Write-to-read latency through the array: 1 cycle. The same-cycle value is supplied by the bypass.
- Issue-to-stall latency: an instruction firing in cycle N raises `pend[rd]` visible in cycle N+1. A dependent instruction in N+1 stalls until its write-back cycle, where the bypass permits it to fire.
- Reset asserted mid-operation discards all pending state immediately. Write-backs arriving after release for lost reservations set o_sb_err; the pipeline must be flushed alongside.
- Simultaneous issue with rd == rs1 of the same instruction: the hazard check uses the pre-update counter, so it does not self-stall.

## Test plan

- Reset then read: after reset, rs1id=5, rs2id=0 -> o_idu_rs1=0, o_idu_rs2=0, o_busy=0, o_iss_ready=1.
- Write then read plus bypass:
  - wb rdid=3, data=0xDEAD -> same cycle, rs1id=3 reads 0xDEAD.
  - Next cycle, with no write-back, rs1id=3 still reads 0xDEAD.
  - wb to rdid=0 with data=7 -> rs1id=0 reads 0.
- RAW stall: issue rdwen rd=7. Next cycle present rs1en rs1id=7 -> o_iss_ready=0 for each cycle until the wb to 7 arrives. In that cycle o_iss_ready=1 and o_idu_rs1 = the wb data. The following cycle `pend[7]=0` and o_busy=0.
- Counter saturation (PCNTW=2): issue three writes to rd=9 -> `pend[9]=3`, and a fourth issue to rd=9 has o_iss_ready=0. Then:
  - Same cycle wb to 9 -> ready=1, fire, `pend[9]` stays 3.
  - Three further wbs -> `pend[9]=0`.
- Underflow: wb rdid=4 with `pend[4]=0` -> o_sb_err=1 next cycle and it stays 1. Reset -> 0.
- Reset mid-flight: issue rd=12, assert i_rst_n low asynchronously mid-cycle -> o_busy=0 immediately, and rf[12] reads 0 after release.
